// File: rtl/ofs_plat_utils_dcfifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// ofs_plat_utils_dcfifo_arb_pkg
//
// Shared definitions for the dual-clock FIFO write arbiter and the matching
// read-side demultiplexer. The FIFO word layout is {eop, idx, payload}, with
// the payload in the low bits, the source index above it and EOP on top.
//
// Contents:
//   t_arb_state      arbiter state (idle / packet in progress)
//   fifo_data_width  packed FIFO word width for a given payload and N
//   idx_lsb/eop_bit  field offsets inside the packed word
//   IDX_LSB/EOP_BIT  field offsets for the default configuration (32b, N=4)
// ----------------------------------------------------------------------------
package ofs_plat_utils_dcfifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } t_arb_state;

  // Width of the source-index field for n requesters.
  function automatic int idx_width(input int n_req);
    return $clog2(n_req);
  endfunction

  // Total FIFO word width: payload + source index + EOP flag.
  function automatic int fifo_data_width(input int data_width, input int n_req);
    return data_width + idx_width(n_req) + 1;
  endfunction

  // Lowest bit of the source-index field.
  function automatic int idx_lsb(input int data_width);
    return data_width;
  endfunction

  // Position of the EOP flag (the MSB of the word).
  function automatic int eop_bit(input int data_width, input int n_req);
    return data_width + idx_width(n_req);
  endfunction

  // Offsets for the default configuration, handy for the read-side demux.
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N_REQ      = 4;
  localparam int IDX_LSB        = idx_lsb(DEF_DATA_WIDTH);
  localparam int EOP_BIT        = eop_bit(DEF_DATA_WIDTH, DEF_N_REQ);

endpackage : ofs_plat_utils_dcfifo_arb_pkg

// File: rtl/ofs_plat_utils_rr_pick.sv
// ----------------------------------------------------------------------------
// ofs_plat_utils_rr_pick
//
// Purely combinational round-robin picker. Starting at (last + 1) mod N and
// wrapping upward, returns the first index whose request bit is set.
//
// Ports:
//   req        in   N            request vector
//   last       in   $clog2(N)    most recently granted index
//   gnt_valid  out  1            at least one request is set
//   gnt_idx    out  $clog2(N)    chosen index (0 when gnt_valid is low)
// ----------------------------------------------------------------------------
module ofs_plat_utils_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  int w_base;
  int w_cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that skips the assignment infers a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_cand    = 0;

    // Explicit wrap so non-power-of-2 N never searches an index >= N.
    w_base = (int'(last) >= N - 1) ? 0 : int'(last) + 1;

    // Walk the offsets from farthest to nearest so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = w_base + k;
      if (w_cand >= N) begin
        w_cand = w_cand - N;
      end
      if (req[IW'(w_cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(w_cand);
      end
    end
  end

endmodule : ofs_plat_utils_rr_pick

// File: rtl/ofs_plat_utils_dcfifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// ofs_plat_utils_dcfifo_wr_arbiter
//
// Shares the single write port of a dual-clock FIFO among N_REQ requesters in
// the FIFO write-clock domain. Round-robin arbitration with packet locking:
// once a requester's first beat is accepted it owns the port until its EOP
// beat is accepted. Each FIFO word carries {eop, idx, payload} so the read
// side can demultiplex.
//
// Back-pressure comes from the FIFO's registered wralmfull. Because that flag
// is one cycle late and the output word is registered here, the FIFO must use
// ALMOST_FULL_THRESHOLD >= 2. Drive the FIFO aclr from the same reset so that
// a packet cut off by reset is discarded; no synthetic EOP is generated.
//
// Ports:
//   clk             in   1                        write clock (FIFO wrclk)
//   reset           in   1                        synchronous, active high
//   in_valid        in   N_REQ                    per-requester beat valid
//   in_data         in   N_REQ*DATA_WIDTH         requester i at [i*DW +: DW]
//   in_eop          in   N_REQ                    last beat of packet
//   in_ready        out  N_REQ                    beat accepted on valid&ready
//   fifo_wralmfull  in   1                        FIFO almost-full (registered)
//   fifo_wrreq      out  1                        FIFO write request
//   fifo_data       out  DATA_WIDTH+IDX_WIDTH+1   {eop, idx, payload}
//   locked          out  1                        packet in progress
//   owner           out  IDX_WIDTH                current / most recent grant
// ----------------------------------------------------------------------------
module ofs_plat_utils_dcfifo_wr_arbiter
  import ofs_plat_utils_dcfifo_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_WIDTH  = $clog2(N_REQ),
  localparam int FIFO_WIDTH = fifo_data_width(DATA_WIDTH, N_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              in_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   in_data,
  input  logic [N_REQ-1:0]              in_eop,
  output logic [N_REQ-1:0]              in_ready,
  input  logic                          fifo_wralmfull,
  output logic                          fifo_wrreq,
  output logic [FIFO_WIDTH-1:0]         fifo_data,
  output logic                          locked,
  output logic [IDX_WIDTH-1:0]          owner
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  t_arb_state            r_state;
  t_arb_state            w_state_nxt;
  logic [IDX_WIDTH-1:0]  r_owner;
  logic [IDX_WIDTH-1:0]  w_owner_nxt;
  logic                  r_wrreq;
  logic [FIFO_WIDTH-1:0] r_data;

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  logic                  w_pick_valid;
  logic [IDX_WIDTH-1:0]  w_pick_idx;
  logic                  w_gnt_any;
  logic [IDX_WIDTH-1:0]  w_gnt_idx;
  logic [N_REQ-1:0]      w_grant;
  logic                  w_accept_ok;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_eop;

  ofs_plat_utils_rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req       (in_valid),
    .last      (r_owner),
    .gnt_valid (w_pick_valid),
    .gnt_idx   (w_pick_idx)
  );

  // While locked the owner holds the grant whether or not it is presenting a
  // beat, so its ready never depends on its own valid and it may idle freely.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (r_state == ARB_LOCKED) begin
      w_gnt_any = 1'b1;
      w_gnt_idx = r_owner;
    end else begin
      w_gnt_any = w_pick_valid;
      w_gnt_idx = w_pick_idx;
    end
  end

  // Decode the grant to one-hot and mux the granted requester's beat.
  always_comb begin
    w_grant    = '0;
    w_sel_data = '0;
    w_sel_eop  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_any && (w_gnt_idx == IDX_WIDTH'(i))) begin
        w_grant[i] = 1'b1;
        w_sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_eop  = in_eop[i];
      end
    end
  end

  // Almost-full stalls every requester in the same cycle, locked or not.
  assign w_accept_ok = !reset && !fifo_wralmfull;
  assign in_ready    = w_grant & {N_REQ{w_accept_ok}};
  assign w_xfer      = |(in_valid & in_ready);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    if (w_xfer) begin
      unique case (r_state)
        ARB_IDLE: begin
          // A single-beat packet records the owner but never locks, so the
          // next search still moves past it.
          w_owner_nxt = w_gnt_idx;
          w_state_nxt = w_sel_eop ? ARB_IDLE : ARB_LOCKED;
        end
        ARB_LOCKED: begin
          // Owner is left in place so the next search starts at owner+1.
          if (w_sel_eop) begin
            w_state_nxt = ARB_IDLE;
          end
        end
        default: begin
          w_state_nxt = ARB_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_owner <= IDX_WIDTH'(N_REQ - 1);
      r_wrreq <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_wrreq <= w_xfer;
      if (w_xfer) begin
        r_data <= {w_sel_eop, w_gnt_idx, w_sel_data};
      end
    end
  end

  assign fifo_wrreq = r_wrreq;
  assign fifo_data  = r_data;
  assign locked     = (r_state == ARB_LOCKED);
  assign owner      = r_owner;

  // --------------------------------------------------------------------------
  // Overflow guard: a write may only follow a cycle in which the FIFO did not
  // report almost-full; anything else can push a full FIFO over the edge.
  // --------------------------------------------------------------------------
  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (reset)
      fifo_wrreq |-> !$past(fifo_wralmfull)
  ) else $error("fifo_wrreq issued after fifo_wralmfull was reported");

endmodule : ofs_plat_utils_dcfifo_wr_arbiter

// File: tb/tb_ofs_plat_utils_dcfifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for ofs_plat_utils_dcfifo_wr_arbiter (N_REQ=4, DATA_WIDTH=32).
// A transaction-level model tracks "packet open?" and "last grant" and
// predicts in_ready and the registered FIFO word each cycle. Inputs are
// driven on the falling edge; outputs are sampled on the falling edge, away
// from the active rising edge.
// ----------------------------------------------------------------------------
module tb_ofs_plat_utils_dcfifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int FW = DW + IW + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_eop;
  logic [N-1:0]    in_ready;
  logic            fifo_wralmfull;
  logic            fifo_wrreq;
  logic [FW-1:0]   fifo_data;
  logic            locked;
  logic [IW-1:0]   owner;

  always #5 clk = ~clk;

  ofs_plat_utils_dcfifo_wr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_eop         (in_eop),
    .in_ready       (in_ready),
    .fifo_wralmfull (fifo_wralmfull),
    .fifo_wrreq     (fifo_wrreq),
    .fifo_data      (fifo_data),
    .locked         (locked),
    .owner          (owner)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: is a packet open, who was granted last, and what the
  // registered FIFO outputs should show.
  bit            m_known  = 1'b0;
  bit            m_open   = 1'b0;
  int            m_last   = N - 1;
  bit            m_wrreq  = 1'b0;
  logic [FW-1:0] m_word   = '0;

  // Simple FIFO occupancy model for the integration phase (read side stalled,
  // depth 16, almost-full threshold 2, almost-full registered).
  bit fifo_on  = 1'b0;
  int fifo_cnt = 0;

  // Source-index log for the fairness phase.
  bit log_on = 1'b0;
  int idx_log[$];

  task automatic run_cycle(input bit rst, input logic [N-1:0] v,
                           input logic [N-1:0] e, input bit alm);
    int            g;
    bit            xfer;
    logic [N-1:0]  exp_rdy;
    bit            alm_now;
    @(negedge clk);
    if (m_known) begin
      check("fifo_wrreq", fifo_wrreq, m_wrreq);
      check("fifo_data",  fifo_data,  m_word);
      check("locked",     locked,     m_open);
      check("owner",      owner,      m_last);
    end
    alm_now = fifo_on ? (fifo_cnt >= 14) : alm;
    if (fifo_on && fifo_wrreq === 1'b1) begin
      check("fifo_overflow", (fifo_cnt >= 16), 1'b0);
      fifo_cnt++;
    end
    if (log_on && fifo_wrreq === 1'b1) begin
      idx_log.push_back(int'(fifo_data[DW+IW-1:DW]));
    end

    reset          = rst;
    in_valid       = v;
    in_eop         = e;
    fifo_wralmfull = alm_now;
    for (int i = 0; i < N; i++) begin
      in_data = {in_data[(N-1)*DW-1:0], $urandom()};
    end
    #1;

    // Who may move a beat this cycle.
    g = -1;
    if (!rst && !alm_now) begin
      if (m_open) begin
        g = m_last;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && bit'(v >> ((m_last + k) % N))) begin
            g = (m_last + k) % N;
          end
        end
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("in_ready", in_ready, exp_rdy);
    xfer = (g >= 0) && bit'(v >> g);

    if (rst) begin
      m_known = 1'b1;
      m_open  = 1'b0;
      m_last  = N - 1;
      m_wrreq = 1'b0;
      m_word  = '0;
    end else begin
      m_wrreq = xfer;
      if (xfer) begin
        m_word = {bit'(e >> g), IW'(g), DW'(in_data >> (g * DW))};
        m_last = g;
        m_open = !bit'(e >> g);
      end
    end
  endtask

  initial begin
    logic [N-1:0] rv;
    logic [N-1:0] re;

    reset          = 1'b1;
    in_valid       = '0;
    in_eop         = '0;
    in_data        = '0;
    fifo_wralmfull = 1'b0;

    // Reset state.
    repeat (3) run_cycle(1'b1, 4'hF, 4'hF, 1'b0);

    // Fairness: everybody streams single-beat packets.
    log_on = 1'b1;
    repeat (12) run_cycle(1'b0, 4'hF, 4'hF, 1'b0);
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0);
    log_on = 1'b0;
    check("fair_count", idx_log.size(), 12);
    for (int k = 0; k < idx_log.size(); k++) begin
      check("fair_idx", idx_log[k], k % 4);
    end

    // Packet lock: req1 sends 3 beats while req0/req2 wait; req2 goes next.
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    run_cycle(1'b0, 4'b0001, 4'b0001, 1'b0);
    run_cycle(1'b0, 4'b0010, 4'b0000, 1'b0);
    run_cycle(1'b0, 4'b0111, 4'b0000, 1'b0);
    run_cycle(1'b0, 4'b0111, 4'b0010, 1'b0);
    run_cycle(1'b0, 4'b0101, 4'b0101, 1'b0);
    run_cycle(1'b0, 4'b0000, 4'b0000, 1'b0);
    check("lock_next_owner", owner, 2);

    // Owner bubble: req3 locked and idle for 5 cycles while others wait.
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    run_cycle(1'b0, 4'b1000, 4'b0000, 1'b0);
    repeat (5) run_cycle(1'b0, 4'b0111, 4'b0111, 1'b0);
    check("bubble_ready", in_ready, 4'b1000);
    run_cycle(1'b0, 4'b1111, 4'b1000, 1'b0);
    run_cycle(1'b0, 4'b0111, 4'b0111, 1'b0);

    // Back-pressure for 10 cycles inside a 4-beat packet, then EOP held off
    // by almost-full for two cycles.
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    run_cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
    run_cycle(1'b0, 4'b0001, 4'b0000, 1'b0);
    repeat (10) run_cycle(1'b0, 4'b0011, 4'b0000, 1'b1);
    check("stall_ready", in_ready, 4'b0000);
    run_cycle(1'b0, 4'b0011, 4'b0000, 1'b0);
    repeat (2) run_cycle(1'b0, 4'b0011, 4'b0001, 1'b1);
    run_cycle(1'b0, 4'b0011, 4'b0001, 1'b0);
    run_cycle(1'b0, 4'b0010, 4'b0010, 1'b0);

    // Reset mid-packet: req2 locked after two beats, then reset.
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    run_cycle(1'b0, 4'b0100, 4'b0000, 1'b0);
    run_cycle(1'b0, 4'b0100, 4'b0000, 1'b0);
    run_cycle(1'b1, 4'b0101, 4'b0000, 1'b0);
    run_cycle(1'b0, 4'b0101, 4'b0001, 1'b0);
    check("rst_wrreq",  fifo_wrreq, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_owner",  owner, 3);
    check("rst_grant",  in_ready, 4'b0001);
    run_cycle(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Integration with a stalled depth-16 FIFO (threshold 2).
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    fifo_cnt = 0;
    fifo_on  = 1'b1;
    repeat (80) begin
      rv = N'($urandom()) | 4'b0001;
      re = N'($urandom());
      run_cycle(1'b0, rv, re, 1'b0);
    end
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0);
    fifo_on = 1'b0;
    check("fifo_filled", (fifo_cnt >= 14) && (fifo_cnt <= 16), 1'b1);

    // Randomized traffic with random back-pressure and occasional reset.
    run_cycle(1'b1, 4'h0, 4'h0, 1'b0);
    repeat (600) begin
      rv = N'($urandom());
      re = '0;
      for (int i = 0; i < N; i++) begin
        re = {re[N-2:0], ($urandom_range(2) == 0)};
      end
      run_cycle(($urandom_range(79) == 0), rv, re, ($urandom_range(4) == 0));
    end
    run_cycle(1'b0, 4'h0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ofs_plat_utils_dcfifo_wr_arbiter
